// File: rtl/tawas_pkg.sv
// Shared widths and the writeback queue entry for the Tawas load/store path.
package tawas_pkg;

  localparam int unsigned NUM_THREADS = 4;
  localparam int unsigned THREAD_W    = 2;
  localparam int unsigned SEL_W       = 3;
  localparam int unsigned NUM_REGS    = 8;
  localparam int unsigned DATA_W      = 32;

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/tawas_wb_fifo.sv
// Single-thread writeback FIFO; wrap bit on each pointer separates full from empty.
module tawas_wb_fifo
  import tawas_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t din,
  output logic      full_c,
  output logic      empty_c,
  output wb_entry_t head_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  wb_entry_t     mem_q [DEPTH];
  wb_entry_t     mem_d [DEPTH];

  assign empty_c = (wr_ptr_q == rd_ptr_q);
  assign full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_c  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push && !full_c) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d                = wr_ptr_q + PW'(1);
    end
    if (pop && !empty_c) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only read while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/tawas_ls_wb_sched.sv
// Load-writeback scheduler: per-thread return queues drained in the owning thread's
// slot, plus a per-thread pending-register scoreboard for load-use stalls.
module tawas_ls_wb_sched
  import tawas_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [THREAD_W-1:0]    SLICE,
  input  logic                   RTN_VLD,
  input  logic [THREAD_W-1:0]    RTN_THREAD,
  input  logic [SEL_W-1:0]       RTN_SEL,
  input  logic [DATA_W-1:0]      RTN_DATA,
  output logic                   RTN_RDY,
  input  logic                   ISSUE_VLD,
  input  logic [THREAD_W-1:0]    ISSUE_THREAD,
  input  logic [SEL_W-1:0]       ISSUE_SEL,
  output logic [NUM_REGS-1:0]    PEND_MASK,
  output logic [NUM_THREADS-1:0] THREAD_FULL,
  output logic                   LS_LOAD_VLD,
  output logic [SEL_W-1:0]       LS_LOAD_SEL,
  output logic [DATA_W-1:0]      LS_LOAD
);

  logic [NUM_THREADS-1:0] push, pop, full, empty;
  wb_entry_t              head [NUM_THREADS];
  wb_entry_t              rtn_entry;
  logic [THREAD_W-1:0]    pop_thread;

  logic                                 ld_vld_q, ld_vld_d;
  logic [SEL_W-1:0]                     ld_sel_q, ld_sel_d;
  logic [DATA_W-1:0]                    ld_data_q, ld_data_d;
  logic [NUM_THREADS-1:0][NUM_REGS-1:0] pend_q, pend_d;

  assign rtn_entry = '{sel: RTN_SEL, data: RTN_DATA};
  // Popping for the next slot makes the registered output land in the owner's slot.
  assign pop_thread = SLICE + THREAD_W'(1);

  always_comb begin
    push             = '0;
    pop              = '0;
    push[RTN_THREAD] = RTN_VLD & ~full[RTN_THREAD];
    pop[pop_thread]  = ~empty[pop_thread];
  end

  for (genvar t = 0; t < NUM_THREADS; t++) begin : g_fifo
    tawas_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (CLK),
      .rst     (RST),
      .push    (push[t]),
      .pop     (pop[t]),
      .din     (rtn_entry),
      .full_c  (full[t]),
      .empty_c (empty[t]),
      .head_c  (head[t])
    );
  end

  // Writeback register and scoreboard; a same-edge issue re-sets the bit being cleared.
  always_comb begin
    ld_vld_d  = 1'b0;
    ld_sel_d  = ld_sel_q;
    ld_data_d = ld_data_q;
    pend_d    = pend_q;
    if (!empty[pop_thread]) begin
      ld_vld_d  = 1'b1;
      ld_sel_d  = head[pop_thread].sel;
      ld_data_d = head[pop_thread].data;
    end
    if (ld_vld_q) begin
      pend_d[SLICE][ld_sel_q] = 1'b0;
    end
    if (ISSUE_VLD) begin
      pend_d[ISSUE_THREAD][ISSUE_SEL] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ld_vld_q  <= 1'b0;
      ld_sel_q  <= '0;
      ld_data_q <= '0;
      pend_q    <= '0;
    end else begin
      ld_vld_q  <= ld_vld_d;
      ld_sel_q  <= ld_sel_d;
      ld_data_q <= ld_data_d;
      pend_q    <= pend_d;
    end
  end

  assign RTN_RDY     = ~full[RTN_THREAD];
  assign THREAD_FULL = full;
  assign PEND_MASK   = pend_q[SLICE];
  assign LS_LOAD_VLD = ld_vld_q;
  assign LS_LOAD_SEL = ld_sel_q;
  assign LS_LOAD     = ld_data_q;

endmodule

// File: doc/tawas_ls_wb_sched.md
# tawas_ls_wb_sched

Load-writeback scheduler for the Tawas core. It accepts load-return data from the bus interface for any of the four hardware threads at any time. Each thread has its own queue. The block presents each queued result on the register file load-write port (LS_LOAD_VLD/SEL/DATA) only in a cycle where SLICE equals the owning thread, which is the only slot where the register file routes that port to that thread's bank. It also keeps a per-thread pending-register scoreboard so the issue stage can stall on load-use hazards.

## Interface
- DEPTH, 2: entries per thread queue (power of two, ≥2)
- CLK  in  1  clock
- RST  in  1  reset; synchronous, active-high
- SLICE  in  2  current thread slot; increments by 1 mod 4 every cycle
- RTN_VLD  in  1  load-return data valid
- RTN_THREAD  in  2  owning thread of return
- RTN_SEL  in  3  destination register
- RTN_DATA  in  32  load data
- RTN_RDY  out  1  return accepted when RTN_VLD & RTN_RDY
- ISSUE_VLD  in  1  a load was issued this cycle; marks register pending
- ISSUE_THREAD  in  2  issuing thread
- ISSUE_SEL  in  3  load destination register
- PEND_MASK  out  8  pending-register bitmap of thread SLICE
- THREAD_FULL  out  4  bit t set = queue t full
- LS_LOAD_VLD  out  1  register file load write enable
- LS_LOAD_SEL  out  3  register file load destination
- LS_LOAD  out  32  register file load data

## Operation
- Four independent FIFOs, each DEPTH entries of {sel[2:0], data[31:0]}. FIFO t holds returns for thread t only.
- **Push**
  - RTN_RDY = ~full[RTN_THREAD], combinational.
  - Push occurs at the edge when RTN_VLD & RTN_RDY.
  - Full is evaluated before any same-edge pop. A full queue refuses the return even if it pops on that edge.
- **Pop / writeback**
  - At each edge, let n = SLICE+1 (mod 4).
  - If FIFO n is non-empty before the edge, register its head into LS_LOAD_SEL/LS_LOAD, set LS_LOAD_VLD=1, and pop.
  - Otherwise LS_LOAD_VLD=0. SEL and DATA hold their last values.
  - Result: LS_LOAD_VLD is high only in cycles where SLICE equals the owning thread. At most one writeback per cycle.
  - An entry pushed at an edge is not eligible for pop at that same edge.
- **Scoreboard**
  - pend[t][r] is set at the edge when ISSUE_VLD, ISSUE_THREAD=t, ISSUE_SEL=r.
  - pend[t][r] is cleared at the edge ending the cycle where LS_LOAD_VLD=1 with SLICE=t and LS_LOAD_SEL=r. This is the same edge the register file commits the write.
  - Set and clear of the same bit on the same edge: set wins. This covers a back-to-back load to the same register.
  - PEND_MASK = pend[SLICE], combinational mux of registered state.
- **Ordering**
  - Writebacks within a thread are in return order.
  - Threads never block each other.
- **Reset values**
  - All FIFOs empty; pend all zero.
  - LS_LOAD_VLD=0, LS_LOAD_SEL=0, LS_LOAD=0.
  - THREAD_FULL=0, RTN_RDY=1, PEND_MASK=0.
- **Reset mid-operation:** queued returns and pending bits are discarded. No writeback occurs in the cycle after reset deasserts.

## Timing
- Outputs LS_LOAD_* are registered. THREAD_FULL is a registered-state decode.
- Minimum return-to-writeback latency:
  - Return for thread t accepted at edge e (while SLICE=t-1) writes back at SLICE=t+4, i.e. 5 cycles later.
  - General case: 1 cycle to enqueue, then wait for the next pop edge where SLICE+1=t, then the output cycle.
  - Maximum extra wait per queued entry ahead is 4 cycles, since each thread gets one pop per 4-cycle rotation.
- Sustained throughput: one writeback per thread per 4 cycles. A thread whose return rate exceeds this fills its queue and deasserts RTN_RDY for that thread only.

## Structure
- Shared package tawas_pkg:
  - thread count (4), register select width (3), data width (32)
  - wb_entry_t struct {sel, data}
- Sub-module tawas_wb_fifo: single-thread synchronous FIFO with push/pop/full/empty/head, pointer wrap at DEPTH with an extra wrap bit. Instantiated 4x.
- Top holds pop select, output registers and scoreboard.

## Test plan
- **Basic writeback:**
  - Stimulus: ISSUE thread 2 sel 5; return thread 2 sel 5 data 0xDEADBEEF accepted while SLICE=1.
  - Required: LS_LOAD_VLD only in the cycle SLICE=2, 5 cycles after acceptance, with SEL=5, DATA=0xDEADBEEF. PEND_MASK[5] at SLICE=2 is 1 before that write and 0 after it.
- **Backpressure:** with DEPTH=2, three back-to-back returns for thread 0 (data 1,2,3).
  - Third return sees RTN_RDY=0 until the first pop; THREAD_FULL[0]=1 meanwhile.
  - Writebacks of 1, 2, 3 occur at successive SLICE=0 slots, 4 cycles apart.
- **Thread independence:** thread 3 queue full while returns arrive for thread 1.
  - Thread 1 returns are accepted immediately.
  - Thread 1 writebacks occur at SLICE=1 unaffected.
- **Scoreboard set/clear collision:** ISSUE thread 1 sel 4 in the same cycle a writeback thread 1 sel 4 is output.
  - pend[1][4] remains 1 afterwards.
  - It clears on the second writeback.
- **Reset mid-operation:** RST for 1 cycle with 2 entries queued per thread.
  - Afterwards LS_LOAD_VLD=0 for 8 cycles, PEND_MASK=0, RTN_RDY=1.
- **Random soak:** random returns and issues across all threads, with a reference model comparing every register-file write.
  - Required: SLICE matches the owning thread on every write, and per-thread order is preserved.
